// File: rtl/run_control_pkg.sv
// Shared definitions for the run/stop front-panel control: FSM state encoding
// and the debounce counter width, reused by any panel logic that decodes state.
package run_control_pkg;

    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        ST_STOPPED  = 2'b00,
        ST_RUNNING  = 2'b01,
        ST_STEPPING = 2'b10,
        ST_STOPPING = 2'b11
    } state_e;

endpackage

// File: rtl/run_control_debounce.sv
// One front-panel switch: two-flop synchroniser, stability counter, debounced
// level and a registered one-cycle press pulse on the debounced falling edge.
module switch_debounce
    import run_control_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_n_i,
    output logic press_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             deb_q, deb_d;
    logic             deb_dly_q;
    logic             press_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The edge on which the count would reach DEBOUNCE_CYCLES accepts the new level.
    always_comb begin
        cnt_d = '0;
        deb_d = deb_q;
        if (sync2_q != deb_q) begin
            if (cnt_q == CNT_LAST) begin
                deb_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            deb_q     <= 1'b1;
            deb_dly_q <= 1'b1;
            cnt_q     <= '0;
            press_q   <= 1'b0;
        end else begin
            sync1_q   <= sw_n_i;
            sync2_q   <= sync1_q;
            deb_q     <= deb_d;
            cnt_q     <= cnt_d;
            deb_dly_q <= deb_q;
            press_q   <= deb_dly_q & ~deb_q;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/run_control.sv
// Front-panel RUN/STOP/STEP control: debounced switch presses and CPU halt/fetch
// drive a four-state FSM producing the CPU clock enable and panel lamps.
module run_control
    import run_control_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_run_n,
    input  logic sw_stop_n,
    input  logic sw_step_n,
    input  logic halt,
    input  logic fetch,
    output logic cpu_en,
    output logic run,
    output logic halted
);

    logic   run_press, stop_press, step_press;
    state_e state_q, state_d;
    logic   halted_q, halted_d;
    logic   cpu_en_q, run_q;

    switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_sw (
        .clk(clk), .rst(rst), .sw_n_i(sw_run_n), .press_o(run_press)
    );

    switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_stop_sw (
        .clk(clk), .rst(rst), .sw_n_i(sw_stop_n), .press_o(stop_press)
    );

    switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_sw (
        .clk(clk), .rst(rst), .sw_n_i(sw_step_n), .press_o(step_press)
    );

    // Halt outranks fetch and presses whenever the CPU is clocked.
    always_comb begin
        state_d  = state_q;
        halted_d = halted_q;
        if (state_q == ST_STOPPED) begin
            if (run_press) begin
                state_d  = ST_RUNNING;
                halted_d = 1'b0;
            end else if (step_press) begin
                state_d  = ST_STEPPING;
                halted_d = 1'b0;
            end
        end else if (halt) begin
            state_d  = ST_STOPPED;
            halted_d = 1'b1;
        end else begin
            case (state_q)
                ST_RUNNING: begin
                    if (stop_press) state_d = ST_STOPPING;
                end
                ST_STEPPING, ST_STOPPING: begin
                    if (fetch) state_d = ST_STOPPED;
                end
                default: state_d = ST_STOPPED;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_STOPPED;
            halted_q <= 1'b0;
            cpu_en_q <= 1'b0;
            run_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_d;
            cpu_en_q <= (state_d != ST_STOPPED);
            run_q    <= (state_d == ST_RUNNING);
        end
    end

    assign cpu_en = cpu_en_q;
    assign run    = run_q;
    assign halted = halted_q;

endmodule

// File: tb/tb_run_control.sv
// Self-checking bench for run_control with DEBOUNCE_CYCLES=4: directed panel
// scenarios plus randomized switch/halt/fetch traffic against a behavioural model.
module tb_run_control;

    localparam int N = 4;
    localparam int M_STOPPED = 0, M_RUNNING = 1, M_STEPPING = 2, M_STOPPING = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sw_run_n = 1'b1, sw_stop_n = 1'b1, sw_step_n = 1'b1;
    logic halt = 1'b0, fetch = 1'b0;
    logic cpu_en, run, halted;

    int n_checks = 0;
    int n_pass   = 0;

    run_control #(.DEBOUNCE_CYCLES(N)) dut (
        .clk(clk), .rst(rst),
        .sw_run_n(sw_run_n), .sw_stop_n(sw_stop_n), .sw_step_n(sw_step_n),
        .halt(halt), .fetch(fetch),
        .cpu_en(cpu_en), .run(run), .halted(halted)
    );

    always #5 clk = ~clk;

    // Behavioural model: a switch level is accepted once the last N synchronised
    // samples all disagree with the accepted level; the press pulse is seen one
    // edge after a falling acceptance and acted on by the FSM at the edge after.
    int m_state = M_STOPPED;
    bit m_halted = 1'b0;
    bit m_raw_d1[3], m_raw_d2[3];
    bit m_deb[3], m_fell[3], m_press[3];
    bit m_win[3][$];

    function automatic logic [2:0] m_out();
        return {m_state != M_STOPPED, m_state == M_RUNNING, m_halted};
    endfunction

    task automatic model_step();
        bit raw[3];
        bit pr[3];
        bit seen, all_diff, fell_now;
        raw[0] = sw_run_n;
        raw[1] = sw_stop_n;
        raw[2] = sw_step_n;
        if (rst) begin
            m_state  = M_STOPPED;
            m_halted = 1'b0;
            for (int i = 0; i < 3; i++) begin
                m_raw_d1[i] = 1'b1;
                m_raw_d2[i] = 1'b1;
                m_deb[i]    = 1'b1;
                m_fell[i]   = 1'b0;
                m_press[i]  = 1'b0;
                m_win[i].delete();
            end
            return;
        end
        for (int i = 0; i < 3; i++) pr[i] = m_press[i];
        for (int i = 0; i < 3; i++) begin
            seen        = m_raw_d2[i];
            m_raw_d2[i] = m_raw_d1[i];
            m_raw_d1[i] = raw[i];
            m_win[i].push_back(seen);
            if (m_win[i].size() > N) void'(m_win[i].pop_front());
            all_diff = (m_win[i].size() == N);
            foreach (m_win[i][k]) if (m_win[i][k] == m_deb[i]) all_diff = 1'b0;
            fell_now = 1'b0;
            if (all_diff) begin
                m_deb[i] = ~m_deb[i];
                fell_now = (m_deb[i] == 1'b0);
                m_win[i].delete();
            end
            m_press[i] = m_fell[i];
            m_fell[i]  = fell_now;
        end
        if (m_state == M_STOPPED) begin
            if (pr[0]) begin
                m_state = M_RUNNING;  m_halted = 1'b0;
            end else if (pr[2]) begin
                m_state = M_STEPPING; m_halted = 1'b0;
            end
        end else if (halt) begin
            m_state  = M_STOPPED;
            m_halted = 1'b1;
        end else if (m_state == M_RUNNING) begin
            if (pr[1]) m_state = M_STOPPING;
        end else if (fetch) begin
            m_state = M_STOPPED;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sw_run_n = 1'b1; sw_stop_n = 1'b1; sw_step_n = 1'b1;
        halt = 1'b0; fetch = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic go_running();
        sw_run_n = 1'b0;
        repeat (N + 5) tick();
        sw_run_n = 1'b1;
        repeat (N + 4) tick();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({cpu_en, run, halted} !== 3'b000)
            $display("FAIL reset_outputs actual=%b required=000", {cpu_en, run, halted});
        else n_pass++;
        repeat (12) tick();
        n_checks++;
        if ({cpu_en, run, halted} !== 3'b000)
            $display("FAIL idle_after_reset actual=%b required=000", {cpu_en, run, halted});
        else n_pass++;
    endtask

    task automatic test_run_latency();
        logic exp_en;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sw_run_n = 1'b0;
        for (int e = 0; e <= 9; e++) begin
            tick();
            exp_en = (e >= N + 3);
            n_checks++;
            if ({cpu_en, run, halted} !== {exp_en, exp_en, 1'b0})
                $display("FAIL run_latency edge %0d actual=%b required=%b",
                         e, {cpu_en, run, halted}, {exp_en, exp_en, 1'b0});
            else n_pass++;
        end
        sw_run_n = 1'b1;
        repeat (10) tick();
        n_checks++;
        if ({cpu_en, run} !== 2'b11)
            $display("FAIL run_release_no_event actual=%b required=11", {cpu_en, run});
        else n_pass++;
    endtask

    task automatic test_bounce();
        do_reset();
        for (int c = 0; c < 35; c++) begin
            if (c < 20 && (c % 2) == 0) sw_run_n = ~sw_run_n;
            if (c == 20) sw_run_n = 1'b1;
            tick();
            n_checks++;
            if ({cpu_en, run} !== 2'b00 || m_out() !== 3'b000)
                $display("FAIL bounce cyc %0d actual=%b required=000", c, {cpu_en, run, halted});
            else n_pass++;
        end
    endtask

    task automatic test_stop_sequence();
        int guard;
        do_reset();
        go_running();
        sw_stop_n = 1'b0;
        guard = 0;
        while (!m_press[1] && guard < 20) begin
            tick();
            guard++;
        end
        n_checks++;
        if (!m_press[1]) $display("FAIL stop_press_timeout actual=none required=pulse");
        else n_pass++;
        tick();
        n_checks++;
        if ({cpu_en, run, halted} !== 3'b100)
            $display("FAIL stopping_entry actual=%b required=100", {cpu_en, run, halted});
        else n_pass++;
        repeat (3) tick();
        n_checks++;
        if ({cpu_en, run} !== 2'b10)
            $display("FAIL stopping_hold actual=%b required=10", {cpu_en, run});
        else n_pass++;
        fetch = 1'b1;
        tick();
        fetch = 1'b0;
        n_checks++;
        if ({cpu_en, run, halted} !== 3'b000)
            $display("FAIL stopped_after_fetch actual=%b required=000", {cpu_en, run, halted});
        else n_pass++;
        sw_stop_n = 1'b1;
        repeat (N + 4) tick();
    endtask

    task automatic test_step();
        int guard;
        do_reset();
        sw_step_n = 1'b0;
        guard = 0;
        while (!m_press[2] && guard < 20) begin
            tick();
            guard++;
        end
        n_checks++;
        if (!m_press[2]) $display("FAIL step_press_timeout actual=none required=pulse");
        else n_pass++;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if ({cpu_en, run, halted} !== 3'b100)
                $display("FAIL stepping_en cyc %0d actual=%b required=100", c, {cpu_en, run, halted});
            else n_pass++;
        end
        fetch = 1'b1;
        tick();
        fetch = 1'b0;
        n_checks++;
        if (cpu_en !== 1'b0)
            $display("FAIL step_end actual=%b required=0", cpu_en);
        else n_pass++;
        tick();
        fetch = 1'b1;
        tick();
        fetch = 1'b0;
        tick();
        n_checks++;
        if ({cpu_en, run, halted} !== 3'b000)
            $display("FAIL second_fetch actual=%b required=000", {cpu_en, run, halted});
        else n_pass++;
        sw_step_n = 1'b1;
        repeat (N + 4) tick();
    endtask

    task automatic test_halt();
        int guard;
        do_reset();
        go_running();
        halt = 1'b1;
        fetch = 1'b1;
        tick();
        halt = 1'b0;
        fetch = 1'b0;
        n_checks++;
        if ({cpu_en, run, halted} !== 3'b001)
            $display("FAIL halt_stop actual=%b required=001", {cpu_en, run, halted});
        else n_pass++;
        halt = 1'b1;
        repeat (3) tick();
        halt = 1'b0;
        n_checks++;
        if ({cpu_en, run, halted} !== 3'b001)
            $display("FAIL halt_in_stopped actual=%b required=001", {cpu_en, run, halted});
        else n_pass++;
        sw_run_n = 1'b0;
        guard = 0;
        while (cpu_en !== 1'b1 && guard < 20) begin
            tick();
            guard++;
        end
        sw_run_n = 1'b1;
        n_checks++;
        if ({cpu_en, run, halted} !== 3'b110)
            $display("FAIL rerun_after_halt actual=%b required=110", {cpu_en, run, halted});
        else n_pass++;
        repeat (N + 4) tick();
    endtask

    task automatic test_reset_mid_step();
        int guard;
        logic exp_en;
        do_reset();
        sw_step_n = 1'b0;
        guard = 0;
        while (cpu_en !== 1'b1 && guard < 20) begin
            tick();
            guard++;
        end
        n_checks++;
        if (cpu_en !== 1'b1) $display("FAIL step_entry_timeout actual=%b required=1", cpu_en);
        else n_pass++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({cpu_en, run, halted} !== 3'b000)
            $display("FAIL reset_mid_step actual=%b required=000", {cpu_en, run, halted});
        else n_pass++;
        for (int e = 0; e <= 8; e++) begin
            tick();
            exp_en = (e >= N + 3);
            n_checks++;
            if ({cpu_en, run} !== {exp_en, 1'b0})
                $display("FAIL restep_latency edge %0d actual=%b required=%b",
                         e, {cpu_en, run}, {exp_en, 1'b0});
            else n_pass++;
        end
        sw_step_n = 1'b1;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 7) == 0) sw_run_n  = ~sw_run_n;
            if ($urandom_range(0, 9) == 0) sw_stop_n = ~sw_stop_n;
            if ($urandom_range(0, 8) == 0) sw_step_n = ~sw_step_n;
            halt  = ($urandom_range(0, 39) == 0);
            fetch = ($urandom_range(0, 5) == 0);
            rst   = ($urandom_range(0, 249) == 0);
            tick();
            n_checks++;
            if ({cpu_en, run, halted} !== m_out())
                $display("FAIL random cyc %0d actual=%b required=%b", c, {cpu_en, run, halted}, m_out());
            else n_pass++;
        end
        rst = 1'b0;
        halt = 1'b0;
        fetch = 1'b0;
    endtask

    initial begin
        test_reset();
        test_run_latency();
        test_bounce();
        test_stop_sequence();
        test_step();
        test_halt();
        test_reset_mid_step();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
